dvp_bayer_emulator: RTL and testbench
=====================================

# dvp_bayer_emulator

Camera-side transmitter for the OV7670 raw Bayer DVP interface. Reads one byte per pixel from video memory in row-major order and drives `D`/`HREF`/`VSYNC` with OV7670-style frame and line timing, so the capture path can run without a sensor. Sits between a frame-buffer read port and the capture input pins. It is used for loopback simulation and on-board self-test.

## Interface
Parameters:
- `RESOLUTION_WIDTH`, 640: active pixels (bytes) per line.
- `RESOLUTION_HEIGHT`, 480: active lines per frame.
- `VSYNC_LINES`, 3: lines with `VSYNC` high at frame start.
- `V_BACK_PORCH`, 17: blank lines after `VSYNC` falls, before the first active line.
- `V_FRONT_PORCH`, 10: blank lines after the last active line.
- `H_BLANK`, 144: blank cycles after the active part of every line. Must be ≥ 1.

Ports (AW = `$clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT)`):
- `PCLK` in 1: the only clock. All logic runs on the rising edge.
- `RST_N` in 1: reset, synchronous and active-low.
- `enable` in 1: level. High starts frames and keeps them running back to back.
- `r_addr` out AW: video-memory read address.
- `r_en` out 1: read strobe, high on cycles that issue a valid `r_addr`.
- `r_data` in 8: memory read data, valid exactly 1 cycle after `r_en`.
- `D` out 8: pixel byte.
- `HREF` out 1: line-valid.
- `VSYNC` out 1: frame sync, active high.
- `busy` out 1: high while a frame is in progress.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
- Every line is `RESOLUTION_WIDTH + H_BLANK` cycles long.
- Frame layout, in order:
  - `VSYNC_LINES` sync lines
  - `V_BACK_PORCH` blank lines
  - `RESOLUTION_HEIGHT` active lines
  - `V_FRONT_PORCH` blank lines
- In an active line, the first `RESOLUTION_WIDTH` cycles are pixels and the rest are blank.
- States:
  - IDLE → SYNC when `enable` = 1.
  - SYNC → BACK after `VSYNC_LINES` lines.
  - BACK → ACTIVE after `V_BACK_PORCH` lines.
  - ACTIVE → FRONT after `RESOLUTION_HEIGHT` lines.
  - FRONT: after `V_FRONT_PORCH` lines, go to SYNC if `enable` = 1, else IDLE.
  - A parameter of 0 skips its state.
- Counters:
  - `h_cnt` runs 0..`RESOLUTION_WIDTH+H_BLANK-1`.
  - `line_cnt` counts lines within the current state. It clears on each state change.
- Read issue: `r_en` = 1 and `r_addr` = pixel index in ACTIVE when `h_cnt < RESOLUTION_WIDTH`.
  - Pixel index is 0 at the start of each frame and increments by 1 per issued read.
  - It reaches `W*H-1` on the last pixel and never wraps inside a frame.
- When `r_en` = 0, `r_addr` holds its last value.
- Output stage delays the internal timing by 2 cycles to cover memory latency:
  - `HREF` and `VSYNC` are the internal signals registered twice.
  - `D` is registered from `r_data` when the delayed read strobe is high, and is 0 otherwise.
- `busy` is 1 from the SYNC entry cycle through the last FRONT cycle.
- `frame_done` pulses on the last FRONT cycle, or on the last ACTIVE-line cycle if `V_FRONT_PORCH` = 0.
- `enable` falling mid-frame has no effect. The current frame completes, then the block enters IDLE.
- `enable` rising while not IDLE is ignored.

## Timing
- Reset values on the `PCLK` edge with `RST_N` = 0: state IDLE, counters 0, and all outputs 0:
  - `D`, `HREF`, `VSYNC`, `r_addr`, `r_en`, `busy`, `frame_done`.
- Reset mid-frame aborts immediately at that edge. The next frame starts at SYNC with pixel index 0.
- Start latency:
  - `enable` sampled high at edge N → internal SYNC from edge N.
  - `VSYNC` pin high from edge N+2.
  - `busy` high from edge N.
- Pin alignment: `r_en` for pixel k at cycle t, `r_data` valid at t+1, `D` = byte k with `HREF` = 1 at cycle t+2.
- `HREF` is high for exactly `RESOLUTION_WIDTH` consecutive cycles per active line. It is never high while `VSYNC` is high.
- Back-to-back frames have no gap. The cycle after the last FRONT cycle is SYNC line 0, cycle 0.

## Test plan
- Small frame: W=4, H=2, `VSYNC_LINES`=1, V_BP=1, V_FP=1, `H_BLANK`=2. Pulse `enable` for 1 cycle → frame = 5 lines × 6 cycles = 30 cycles.
  - `VSYNC` high for 6 cycles.
  - `HREF` high 4 cycles on lines 3–4.
  - `frame_done` pulses once, then the block returns to IDLE.
- Data path: memory[k] = k+0x10 → `D` = 0x10..0x17 on consecutive `HREF` cycles. `D` = 0 during blanking.
- Continuous `enable`, 3 frames → `frame_done` every 30 cycles and `r_addr` restarts at 0 each frame. Drop `enable` mid-frame 2 → frame 2 completes, then IDLE with `busy` = 0.
- Reset (`RST_N` = 0) asserted on pixel 5 of line 1 → all outputs 0 next cycle. After release with `enable` = 1, a full frame starts with `r_addr` = 0.
- Default parameters, loopback into the raw Bayer capture block:
  - captured memory equals the source memory for all 307200 bytes;
  - 784 cycles per line;
  - 510 lines per frame.
- Zero-parameter case: `V_FRONT_PORCH`=0, `V_BACK_PORCH`=0 → the block goes straight SYNC → ACTIVE, and `frame_done` fires on the last active-line cycle.

Source files
------------

// File: rtl/dvp_bayer_emulator.sv
// OV7670-style raw Bayer DVP transmitter. Pixel bytes are read from a
// frame buffer in row-major order and replayed on D/HREF/VSYNC with the
// sensor's frame and line timing, delayed two cycles to absorb the
// one-cycle memory read latency.
module dvp_bayer_emulator #(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  parameter int VSYNC_LINES       = 3,
  parameter int V_BACK_PORCH      = 17,
  parameter int V_FRONT_PORCH     = 10,
  parameter int H_BLANK           = 144,
  localparam int AW = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT)
) (
  input  logic          PCLK,
  input  logic          RST_N,
  input  logic          enable,
  output logic [AW-1:0] r_addr,
  output logic          r_en,
  input  logic [7:0]    r_data,
  output logic [7:0]    D,
  output logic          HREF,
  output logic          VSYNC,
  output logic          busy,
  output logic          frame_done
);

  localparam int LINE_LEN = RESOLUTION_WIDTH + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_BACK   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_FRONT  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [15:0]   line_cnt_q, line_cnt_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [AW-1:0] last_addr_q;
  logic          href_q1, href_q2, vsync_q1, vsync_q2, ren_q1;
  logic [7:0]    d_q;

  logic line_end, state_end, href_int, vsync_int;

  // Number of lines spent in each frame state.
  function automatic logic [15:0] lines_of(input logic [2:0] s);
    case (s)
      S_SYNC:   lines_of = 16'(VSYNC_LINES);
      S_BACK:   lines_of = 16'(V_BACK_PORCH);
      S_ACTIVE: lines_of = 16'(RESOLUTION_HEIGHT);
      S_FRONT:  lines_of = 16'(V_FRONT_PORCH);
      default:  lines_of = 16'd0;
    endcase
  endfunction

  // Frame order; after the front porch the enable level picks SYNC or IDLE.
  function automatic logic [2:0] succ(input logic [2:0] s, input logic en);
    case (s)
      S_SYNC:   succ = S_BACK;
      S_BACK:   succ = S_ACTIVE;
      S_ACTIVE: succ = S_FRONT;
      S_FRONT:  succ = en ? S_SYNC : S_IDLE;
      default:  succ = S_IDLE;
    endcase
  endfunction

  // Walk past states configured with zero lines.
  function automatic logic [2:0] settle(input logic [2:0] s, input logic en);
    logic [2:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (r != S_IDLE && lines_of(r) == 16'd0) r = succ(r, en);
    end
    settle = r;
  endfunction

  assign line_end  = (h_cnt_q == HW'(LINE_LEN - 1));
  assign state_end = line_end && (line_cnt_q == lines_of(state_q) - 16'd1);
  assign href_int  = (state_q == S_ACTIVE) && (h_cnt_q < HW'(RESOLUTION_WIDTH));
  assign vsync_int = (state_q == S_SYNC);

  assign r_en       = href_int;
  assign r_addr     = r_en ? pix_q : last_addr_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = state_end &&
                      ((state_q == S_FRONT) ||
                       (state_q == S_ACTIVE && V_FRONT_PORCH == 0));
  assign D          = d_q;
  assign HREF       = href_q2;
  assign VSYNC      = vsync_q2;

  // Next-state logic for the frame FSM, line/pixel counters and read index.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    h_cnt_d    = h_cnt_q;
    line_cnt_d = line_cnt_q;
    pix_d      = pix_q;
    if (state_q == S_IDLE) begin
      h_cnt_d    = '0;
      line_cnt_d = '0;
      pix_d      = '0;
      if (enable) state_d = settle(S_SYNC, 1'b1);
    end else begin
      h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
      if (line_end) line_cnt_d = line_cnt_q + 16'd1;
      if (r_en) pix_d = pix_q + AW'(1);
      if (state_q != S_ACTIVE) pix_d = '0;
      if (state_end) begin
        state_d    = settle(succ(state_q, enable), enable);
        line_cnt_d = '0;
        if (state_q == S_ACTIVE) pix_d = '0;
      end
    end
  end

  // State, counters and the two-stage output pipeline.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST_N) begin
      state_q     <= S_IDLE;
      h_cnt_q     <= '0;
      line_cnt_q  <= '0;
      pix_q       <= '0;
      last_addr_q <= '0;
      href_q1     <= 1'b0;
      href_q2     <= 1'b0;
      vsync_q1    <= 1'b0;
      vsync_q2    <= 1'b0;
      ren_q1      <= 1'b0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      line_cnt_q  <= line_cnt_d;
      pix_q       <= pix_d;
      last_addr_q <= r_addr;
      href_q1     <= href_int;
      href_q2     <= href_q1;
      vsync_q1    <= vsync_int;
      vsync_q2    <= vsync_q1;
      ren_q1      <= r_en;
      d_q         <= ren_q1 ? r_data : 8'd0;
    end
  end

endmodule

// File: tb/tb_dvp_bayer_emulator.sv
// Bench for dvp_bayer_emulator: a small-frame instance and a zero-porch
// instance run side by side under directed and random enable/reset
// stimulus, checked every cycle against a frame-position reference model.
module tb_dvp_bayer_emulator;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int VS = 1;
  localparam int LL = W + HB;
  localparam int AW = $clog2(W * H);

  logic PCLK = 1'b0;
  logic rst_v = 1'b0;
  logic en_v = 1'b0;

  always #5 PCLK = ~PCLK;

  logic [AW-1:0] r_addr0, r_addr1;
  logic          r_en0, r_en1;
  logic [7:0]    r_data0, r_data1, d0, d1;
  logic          href0, href1, vsync0, vsync1, busy0, busy1, fd0, fd1;

  logic [7:0] mem0 [W*H];
  logic [7:0] mem1 [W*H];

  dvp_bayer_emulator #(
    .RESOLUTION_WIDTH(W), .RESOLUTION_HEIGHT(H), .VSYNC_LINES(VS),
    .V_BACK_PORCH(1), .V_FRONT_PORCH(1), .H_BLANK(HB)
  ) u_dut0 (
    .PCLK(PCLK), .RST_N(rst_v), .enable(en_v),
    .r_addr(r_addr0), .r_en(r_en0), .r_data(r_data0),
    .D(d0), .HREF(href0), .VSYNC(vsync0), .busy(busy0), .frame_done(fd0)
  );

  dvp_bayer_emulator #(
    .RESOLUTION_WIDTH(W), .RESOLUTION_HEIGHT(H), .VSYNC_LINES(VS),
    .V_BACK_PORCH(0), .V_FRONT_PORCH(0), .H_BLANK(HB)
  ) u_dut1 (
    .PCLK(PCLK), .RST_N(rst_v), .enable(en_v),
    .r_addr(r_addr1), .r_en(r_en1), .r_data(r_data1),
    .D(d1), .HREF(href1), .VSYNC(vsync1), .busy(busy1), .frame_done(fd1)
  );

  // Frame-buffer read ports with one cycle of latency.
  always @(posedge PCLK) begin
    if (r_en0) r_data0 <= mem0[r_addr0];
    if (r_en1) r_data1 <= mem1[r_addr1];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: each instance is described only by its position in
  // the current frame (-1 when idle) plus the position two cycles ago.
  int pos [2][3];
  int last_addr [2];

  function automatic int bp_of(input int i); return (i == 0) ? 1 : 0; endfunction
  function automatic int fp_of(input int i); return (i == 0) ? 1 : 0; endfunction
  function automatic int frame_len(input int i);
    return (VS + bp_of(i) + H + fp_of(i)) * LL;
  endfunction
  function automatic bit is_active(input int i, input int p);
    int line;
    if (p < 0) return 1'b0;
    line = p / LL - VS - bp_of(i);
    return (line >= 0) && (line < H) && (p % LL < W);
  endfunction
  function automatic int pix_of(input int i, input int p);
    return (p / LL - VS - bp_of(i)) * W + (p % LL);
  endfunction

  task automatic model_step(input int i, input bit en, input bit rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) pos[i][k] = -1;
      last_addr[i] = 0;
    end else begin
      pos[i][2] = pos[i][1];
      pos[i][1] = pos[i][0];
      if (pos[i][0] < 0) pos[i][0] = en ? 0 : -1;
      else begin
        pos[i][0]++;
        if (pos[i][0] == frame_len(i)) pos[i][0] = en ? 0 : -1;
      end
    end
  endtask

  task automatic check_dut(input int i, input logic [AW-1:0] addr, input logic ren,
                           input logic [7:0] d, input logic href, input logic vsync,
                           input logic bsy, input logic fd);
    int p0, p2, ea;
    bit eren, ehref, evs;
    logic [7:0] ed;
    string pfx;
    pfx  = $sformatf("dut%0d", i);
    p0   = pos[i][0];
    p2   = pos[i][2];
    eren = is_active(i, p0);
    ea   = eren ? pix_of(i, p0) : last_addr[i];
    last_addr[i] = ea;
    ehref = is_active(i, p2);
    evs   = (p2 >= 0) && (p2 / LL < VS);
    ed    = 8'd0;
    if (ehref) ed = (i == 0) ? mem0[pix_of(i, p2)] : mem1[pix_of(i, p2)];
    check({pfx, ".r_en"},       32'(ren),   32'(eren));
    check({pfx, ".r_addr"},     32'(addr),  32'(ea));
    check({pfx, ".HREF"},       32'(href),  32'(ehref));
    check({pfx, ".VSYNC"},      32'(vsync), 32'(evs));
    check({pfx, ".D"},          32'(d),     32'(ed));
    check({pfx, ".busy"},       32'(bsy),   32'(p0 >= 0));
    check({pfx, ".frame_done"}, 32'(fd),    32'(p0 == frame_len(i) - 1));
  endtask

  // One clock: apply inputs, advance the model at the edge, check 1 ns later.
  task automatic tick(input bit en, input bit rst_n);
    en_v  = en;
    rst_v = rst_n;
    @(posedge PCLK);
    model_step(0, en, rst_n);
    model_step(1, en, rst_n);
    #1;
    check_dut(0, r_addr0, r_en0, d0, href0, vsync0, busy0, fd0);
    check_dut(1, r_addr1, r_en1, d1, href1, vsync1, busy1, fd1);
  endtask

  initial begin
    for (int k = 0; k < W * H; k++) begin
      mem0[k] = 8'($urandom);
      mem1[k] = 8'($urandom);
    end
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) pos[i][k] = -1;
      last_addr[i] = 0;
    end
    r_data0 = 8'd0;
    r_data1 = 8'd0;

    // Reset state.
    repeat (3) tick(1'b0, 1'b0);
    // Single-cycle enable pulse: one frame, then back to idle.
    tick(1'b1, 1'b1);
    repeat (40) tick(1'b0, 1'b1);
    // Continuous enable for several frames, dropped mid-frame.
    repeat (75) tick(1'b1, 1'b1);
    repeat (45) tick(1'b0, 1'b1);
    // Reset in the middle of an active line, then restart.
    tick(1'b1, 1'b1);
    repeat (19) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    repeat (40) tick(1'b1, 1'b1);
    repeat (40) tick(1'b0, 1'b1);
    // Random enable levels and occasional resets.
    for (int c = 0; c < 500; c++) begin
      tick($urandom_range(0, 3) != 0 ? (c % 97 < 60) : 1'($urandom),
           $urandom_range(0, 79) != 0);
    end
    repeat (40) tick(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
